load_store_unit: RTL

Memory-stage load/store unit that sits between the execute stage's address/store-data outputs and the data bus, and produces the `dmem_out` word consumed by the register file write-back mux (`WBSel` = 2'b10). It generates byte enables and lane-shifted store data, runs a request/acknowledge handshake with a variable-latency memory, sign- or zero-extends load data, and stalls the pipeline while an access is outstanding.

---
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Data-bus handshake between the load/store unit (master) and a variable-latency memory (slave).
// The request side is held stable while bus_req is high; bus_rdata is valid in the bus_ack cycle.
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_be,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_be,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: byte enables, lane-replicated store data, load extension.
// Latency 2 cycles plus one per wait state; stall holds the pipeline while an access is in flight.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [2:0]              funct3,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  output logic                    stall,
  output logic [31:0]             dmem_out,
  output logic                    fault,
  load_store_unit_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  state_e        state_q;
  logic          bus_req_q;
  logic          bus_we_q;
  logic [31:0]   bus_addr_q;
  logic [3:0]    bus_be_q;
  logic [31:0]   bus_wdata_q;
  logic [2:0]    f3_q;
  logic [1:0]    lo_q;
  logic [31:0]   dmem_q;
  logic          fault_q;
  logic [CW-1:0] cnt_q;

  logic          op_vld;
  logic          f3_ok;
  logic          aligned;
  logic          op_ok;
  logic          op_bad;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;

  // funct3[1:0] encodes the access size for both the signed and unsigned load forms.
  always_comb begin
    op_vld  = mem_read | mem_write;
    f3_ok   = 1'b0;
    aligned = 1'b1;
    be_d    = 4'b1111;
    wdata_d = wdata;

    if (mem_write) begin
      f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b101);
    end

    case (funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{wdata[7:0]}};
      end
      2'b01: begin
        aligned = ~addr[0];
        be_d    = 4'b0011 << {addr[1], 1'b0};
        wdata_d = {2{wdata[15:0]}};
      end
      default: begin
        aligned = (addr[1:0] == 2'b00);
        be_d    = 4'b1111;
        wdata_d = wdata;
      end
    endcase

    op_ok  = op_vld && !(mem_read && mem_write) && f3_ok && aligned;
    op_bad = op_vld && !op_ok;
  end

  function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                              input logic [1:0]  lo,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[8*lo +: 8];
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
      f3_q        <= 3'b000;
      lo_q        <= 2'b00;
      dmem_q      <= 32'h0;
      fault_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (op_ok) begin
            state_q     <= REQ;
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_write;
            bus_addr_q  <= {addr[31:2], 2'b00};
            bus_be_q    <= be_d;
            bus_wdata_q <= wdata_d;
            f3_q        <= funct3;
            lo_q        <= addr[1:0];
            cnt_q       <= '0;
          end else if (op_bad) begin
            fault_q <= 1'b1;
          end
        end
        REQ: begin
          // An ack in the last allowed cycle wins over the timeout.
          if (bus.bus_ack) begin
            state_q   <= DONE;
            bus_req_q <= 1'b0;
            if (!bus_we_q) begin
              dmem_q <= extend_load(f3_q, lo_q, bus.bus_rdata);
            end
          end else if (TO_EN && (cnt_q == TO_LAST)) begin
            state_q   <= DONE;
            bus_req_q <= 1'b0;
            fault_q   <= 1'b1;
            if (!bus_we_q) begin
              dmem_q <= 32'h0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Gated by rst_n so the pipeline is released the moment reset asserts, even with an op on the inputs.
  assign stall = rst_n & ((state_q == REQ) | ((state_q == IDLE) & op_ok));

  assign dmem_out      = dmem_q;
  assign fault         = fault_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule
